hazard_detection_unit: RTL and testbench

//  ID-stage hazard logic of the 5-stage RV32I pipeline, directly downstream of the

---
 rtl/cpu_hazard_pkg.sv | 30 +++
 rtl/hazard_detection_unit_sat_counter.sv | 22 ++
 rtl/hazard_detection_unit.sv | 102 ++++++++++
 tb/tb_hazard_detection_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_hazard_pkg.sv
// Shared encodings for the ID-stage hazard logic: instruction hazard classes,
// operand forwarding selects and the per-operand forwarding priority rule.
package cpu_hazard_pkg;

  typedef enum logic [1:0] {
    NO  = 2'b00,
    ALU = 2'b01,
    LD  = 2'b10,
    SD  = 2'b11
  } hazard_type_t;

  localparam logic [1:0] FWD_RF      = 2'd0;
  localparam logic [1:0] FWD_EXE_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM_ALU = 2'd2;
  localparam logic [1:0] FWD_MEM_LD  = 2'd3;

  // A load sitting in EXE cannot forward yet: the operand either stalls or, for
  // store data, is picked up later on the load->store path, so it yields FWD_RF.
  function automatic logic [1:0] forward_select(input logic         exe_hit,
                                                input logic         mem_hit,
                                                input hazard_type_t te,
                                                input hazard_type_t tm);
    if (exe_hit && te == ALU) return FWD_EXE_ALU;
    if (exe_hit && te == LD)  return FWD_RF;
    if (mem_hit && tm == ALU) return FWD_MEM_ALU;
    if (mem_hit && tm == LD)  return FWD_MEM_LD;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating event counter with synchronous active-high reset; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard unit of the 5-stage RV32I pipeline: load-use stall, taken-branch
// flush, operand forwarding selects, load->store data forwarding and event counters.
module hazard_detection_unit
  import cpu_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_EXE,
  input  logic [REG_AW-1:0] rd_MEM,
  input  logic [REG_AW-1:0] rs2_EXE,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hazard_type_t type_exe;
  hazard_type_t type_mem;
  hazard_type_t id_type;

  logic exe_hit_rs1;
  logic exe_hit_rs2;
  logic mem_hit_rs1;
  logic mem_hit_rs2;
  logic load_use;
  logic stall;
  logic branch_flush;

  always_comb begin
    id_type     = hazard_type_t'(hazard_optype_ID);
    exe_hit_rs1 = (rd_EXE != '0) && rs1use_ID && (rs1_ID == rd_EXE);
    exe_hit_rs2 = (rd_EXE != '0) && rs2use_ID && (rs2_ID == rd_EXE);
    mem_hit_rs1 = (rd_MEM != '0) && rs1use_ID && (rs1_ID == rd_MEM);
    mem_hit_rs2 = (rd_MEM != '0) && rs2use_ID && (rs2_ID == rd_MEM);
  end

  // A store whose only dependency on the EXE load is its data operand does not
  // stall; that value is supplied one cycle later through forward_ctrl_ls.
  always_comb begin
    load_use     = (type_exe == LD) &&
                   (exe_hit_rs1 || (exe_hit_rs2 && !((id_type == SD) && !exe_hit_rs1)));
    stall        = !rst && load_use;
    branch_flush = !rst && Branch_ID && !load_use;
  end

  always_comb begin
    PC_EN_IF        = !stall;
    reg_FD_EN       = !stall;
    reg_DE_flush    = stall;
    reg_FD_flush    = branch_flush;
    forward_ctrl_A  = FWD_RF;
    forward_ctrl_B  = FWD_RF;
    forward_ctrl_ls = 1'b0;
    if (!rst) begin
      forward_ctrl_A  = forward_select(exe_hit_rs1, mem_hit_rs1, type_exe, type_mem);
      forward_ctrl_B  = forward_select(exe_hit_rs2, mem_hit_rs2, type_exe, type_mem);
      forward_ctrl_ls = (type_exe == SD) && (type_mem == LD) &&
                        (rd_MEM != '0) && (rs2_EXE == rd_MEM);
    end
  end

  // A stall turns the instruction entering EXE into a bubble; a branch flush does
  // not, because the branch itself still proceeds down the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_exe <= NO;
      type_mem <= NO;
    end else begin
      type_exe <= load_use ? NO : id_type;
      type_mem <= type_exe;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; narrow counters make saturation
// reachable in a few dozen cycles.
module tb_hazard_detection_unit;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam logic [1:0] OP_NO  = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_SD  = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic              Branch_ID;
  logic              rs1use_ID;
  logic              rs2use_ID;
  logic [1:0]        hazard_optype_ID;
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_EXE;
  logic [REG_AW-1:0] rd_MEM;
  logic [REG_AW-1:0] rs2_EXE;
  logic              PC_EN_IF;
  logic              reg_FD_EN;
  logic              reg_FD_flush;
  logic              reg_DE_flush;
  logic [1:0]        forward_ctrl_A;
  logic [1:0]        forward_ctrl_B;
  logic              forward_ctrl_ls;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  hazard_detection_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .Branch_ID        (Branch_ID),
    .rs1use_ID        (rs1use_ID),
    .rs2use_ID        (rs2use_ID),
    .hazard_optype_ID (hazard_optype_ID),
    .rs1_ID           (rs1_ID),
    .rs2_ID           (rs2_ID),
    .rd_EXE           (rd_EXE),
    .rd_MEM           (rd_MEM),
    .rs2_EXE          (rs2_EXE),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_flush     (reg_FD_flush),
    .reg_DE_flush     (reg_DE_flush),
    .forward_ctrl_A   (forward_ctrl_A),
    .forward_ctrl_B   (forward_ctrl_B),
    .forward_ctrl_ls  (forward_ctrl_ls),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic pc, input logic fden,
                           input logic fdfl, input logic defl, input logic [1:0] fa,
                           input logic [1:0] fb, input logic ls);
    checkOutput({tag, ".PC_EN_IF"},        32'(PC_EN_IF),        32'(pc));
    checkOutput({tag, ".reg_FD_EN"},       32'(reg_FD_EN),       32'(fden));
    checkOutput({tag, ".reg_FD_flush"},    32'(reg_FD_flush),    32'(fdfl));
    checkOutput({tag, ".reg_DE_flush"},    32'(reg_DE_flush),    32'(defl));
    checkOutput({tag, ".forward_ctrl_A"},  32'(forward_ctrl_A),  32'(fa));
    checkOutput({tag, ".forward_ctrl_B"},  32'(forward_ctrl_B),  32'(fb));
    checkOutput({tag, ".forward_ctrl_ls"}, 32'(forward_ctrl_ls), 32'(ls));
  endtask

  task automatic checkCounters(input string tag, input int stalls, input int flushes);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stalls));
    checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(flushes));
  endtask

  // Drives the ID-stage and pipeline inputs, then lets the combinational outputs settle.
  task automatic applyStimulus(input logic br, input logic u1, input logic u2,
                               input logic [1:0] opt, input int r1, input int r2,
                               input int rde, input int rdm, input int r2e);
    Branch_ID        = br;
    rs1use_ID        = u1;
    rs2use_ID        = u2;
    hazard_optype_ID = opt;
    rs1_ID           = REG_AW'(r1);
    rs2_ID           = REG_AW'(r2);
    rd_EXE           = REG_AW'(rde);
    rd_MEM           = REG_AW'(rdm);
    rs2_EXE          = REG_AW'(r2e);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, OP_LD, 5, 6, 5, 6, 6);
    checkCtrl("rst_forced", 1, 1, 0, 0, 2'd0, 2'd0, 0);
    tick();
    tick();
    checkCounters("rst_cleared", 0, 0);

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, OP_NO, 0, 0, 0, 0, 0);
    checkCtrl("idle", 1, 1, 0, 0, 2'd0, 2'd0, 0);

    // add x5 enters EXE
    applyStimulus(1'b0, 1'b0, 1'b0, OP_ALU, 0, 0, 0, 0, 0);
    tick();
    // add x6,x5,x1 with add x5 in EXE
    applyStimulus(1'b0, 1'b1, 1'b1, OP_ALU, 5, 1, 5, 0, 0);
    checkCtrl("alu_fwd_exe", 1, 1, 0, 0, 2'd1, 2'd0, 0);
    tick();

    // EXE=ALU, MEM=ALU
    applyStimulus(1'b0, 1'b1, 1'b0, OP_ALU, 0, 0, 0, 7, 0);
    checkOutput("x0_no_fwd", 32'(forward_ctrl_A), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, OP_ALU, 0, 7, 7, 7, 0);
    checkOutput("exe_over_mem", 32'(forward_ctrl_B), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, OP_ALU, 9, 0, 7, 9, 0);
    checkOutput("mem_alu_fwd", 32'(forward_ctrl_A), 32'd2);
    // lw x5 enters EXE
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LD, 0, 0, 0, 0, 0);
    tick();

    // add x6,x5,x0 behind lw x5, branch also asserted: stall wins
    applyStimulus(1'b0, 1'b1, 1'b1, OP_ALU, 5, 0, 5, 0, 0);
    checkCtrl("load_use", 0, 0, 0, 1, 2'd0, 2'd0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, OP_ALU, 5, 0, 5, 0, 0);
    checkCtrl("load_use_br", 0, 0, 0, 1, 2'd0, 2'd0, 0);
    tick();
    checkCounters("after_stall", 1, 0);

    // load now in MEM, bubble in EXE; branch re-evaluated and taken
    applyStimulus(1'b1, 1'b1, 1'b1, OP_ALU, 5, 0, 0, 5, 0);
    checkCtrl("mem_ld_fwd_br", 1, 1, 1, 0, 2'd3, 2'd0, 0);
    tick();
    checkCounters("after_flush", 1, 1);

    // lw x5 enters EXE
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LD, 0, 0, 0, 0, 0);
    tick();
    // sw x5,0(x2): data-only conflict, no stall
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SD, 2, 5, 5, 0, 0);
    checkCtrl("store_data_dep", 1, 1, 0, 0, 2'd0, 2'd0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SD, 5, 5, 5, 0, 0);
    checkOutput("store_addr_dep", 32'(reg_DE_flush), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, OP_SD, 2, 5, 5, 0, 0);
    tick();

    // sw in EXE, lw in MEM
    applyStimulus(1'b0, 1'b0, 1'b0, OP_NO, 0, 0, 0, 5, 5);
    checkOutput("ls_fwd", 32'(forward_ctrl_ls), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, OP_NO, 0, 0, 0, 5, 6);
    checkOutput("ls_mismatch", 32'(forward_ctrl_ls), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, OP_NO, 0, 0, 0, 0, 0);
    checkOutput("ls_x0", 32'(forward_ctrl_ls), 32'd0);
    checkCounters("before_rst", 1, 1);

    // reset asserted during a stall
    applyStimulus(1'b0, 1'b0, 1'b0, OP_LD, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, OP_ALU, 3, 0, 3, 0, 0);
    checkOutput("stall_pre_rst", 32'(reg_DE_flush), 32'd1);
    rst = 1'b1;
    #1;
    checkCtrl("rst_in_stall", 1, 1, 0, 0, 2'd0, 2'd0, 0);
    tick();
    checkCounters("rst_in_stall", 0, 0);
    rst = 1'b0;
    #1;
    checkCtrl("post_rst", 1, 1, 0, 0, 2'd0, 2'd0, 0);

    // repeated load-use pairs drive stall_cnt into saturation
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, OP_LD, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, OP_ALU, 4, 0, 4, 0, 0);
      tick();
      if (i == 15) checkCounters("sat_reach", 15, 0);
    end
    checkCounters("sat_hold", 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
